// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vectors, FSM encodings and default widths.
// The optional perf counters are enabled by the PIPE_CTRL_PERF_EN macro (see pipe_ctrl.sv).
package pipe_ctrl_pkg;

  localparam int PCTRL_CNT_W   = 6;
  localparam int PCTRL_STALL_W = 6;
  localparam int PCTRL_PERF_W  = 32;

  // Stall bit order: 0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb, 5=wb (reserved)
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [0:0] PCTRL_IDLE = 1'b0;
  localparam logic [0:0] PCTRL_MC   = 1'b1;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating pair of event counters: cycles with any stage held, and flush cycles.
// Instantiated by pipe_ctrl only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
#(
  parameter int PERF_W = PCTRL_PERF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall_any,
  input  logic              i_flush,
  output logic [PERF_W-1:0] o_stall_cyc,
  output logic [PERF_W-1:0] o_flush_cnt
);

  logic [PERF_W-1:0] r_stall_cyc;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      // Counters hold at all-ones rather than wrapping back to zero.
      if (i_stall_any && (r_stall_cyc != '1)) r_stall_cyc <= r_stall_cyc + 1'b1;
      if (i_flush && (r_flush_cnt != '1))     r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cyc = r_stall_cyc;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges ID/EX stall requests, times multi-cycle EX ops, drives flush.
// Define PIPE_CTRL_PERF_EN to add the perf_stall_cyc / perf_flush_cnt counter outputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = PCTRL_CNT_W,
  parameter int STALL_W = PCTRL_STALL_W,
  parameter int PERF_W  = PCTRL_PERF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               ex_mc_start,
  input  logic [CNT_W-1:0]   ex_mc_cycles,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               ex_mc_done,
  output logic               ex_mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_stall_cyc,
  output logic [PERF_W-1:0]  perf_flush_cnt
`endif
);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_mc;
  logic             w_cnt_zero;
  logic             w_mc_start;
  logic             w_ex_stall;
  logic [CNT_W-1:0] w_mc_load;

  assign w_in_mc    = (r_state == PCTRL_MC);
  assign w_cnt_zero = (r_cnt == '0);
  // A start request while already in MC is ignored; the running op keeps its count.
  assign w_mc_start = !w_in_mc && ex_mc_start;
  assign w_ex_stall = w_mc_start || (w_in_mc && !w_cnt_zero) || stallreq_ex;
  // Length 0 behaves as 1: EX is held only in the start cycle.
  assign w_mc_load  = (ex_mc_cycles == '0) ? '0 : ex_mc_cycles - CNT_W'(1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall      = STALL_W'(STALL_NONE);
    flush      = 1'b0;
    new_pc     = ZERO_WORD;
    ex_mc_done = 1'b0;
    ex_mc_busy = 1'b0;
    if (!rst) begin
      ex_mc_busy = w_in_mc;
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else begin
        ex_mc_done = w_in_mc && w_cnt_zero;
        if (w_ex_stall)       stall = STALL_W'(STALL_EX);
        else if (stallreq_id) stall = STALL_W'(STALL_ID);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (rst || flush_req) begin
      r_state <= PCTRL_IDLE;
      r_cnt   <= '0;
    end else if (w_mc_start) begin
      r_state <= PCTRL_MC;
      r_cnt   <= w_mc_load;
    end else if (w_in_mc) begin
      if (w_cnt_zero) r_state <= PCTRL_IDLE;
      else            r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_stall_any (|stall),
    .i_flush     (flush),
    .o_stall_cyc (perf_stall_cyc),
    .o_flush_cnt (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs change 1ns after posedge, outputs checked 4ns after.
// Perf-counter checks compile in only when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done;
  logic        ex_mc_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_mc_done   (ex_mc_done),
    .ex_mc_busy   (ex_mc_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    ex_mc_start  = 1'b0;
    ex_mc_cycles = 6'd0;
    flush_req    = 1'b0;
    flush_pc     = 32'h0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    stallreq_id  = 1'b1;
    stallreq_ex  = 1'b1;
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd4;
    flush_req    = 1'b1;
    flush_pc     = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #3;
      n_checks++;
      if ({stall, flush, ex_mc_done, ex_mc_busy, new_pc} !== {S_NONE, 3'b000, 32'h0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got stall=%b flush=%b done=%b busy=%b new_pc=%h, want all zero",
                 k, stall, flush, ex_mc_done, ex_mc_busy, new_pc);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    #3;
    n_checks++;
    if ({stall, flush, ex_mc_done, ex_mc_busy} !== {S_NONE, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_exit: got stall=%b flush=%b done=%b busy=%b, want idle zeros",
               stall, flush, ex_mc_done, ex_mc_busy);
    end
    tick();
  endtask

  task automatic test_id_stall();
    stallreq_id = 1'b1;
    #3;
    n_checks++;
    if ({stall, flush, ex_mc_busy} !== {S_ID, 2'b00}) begin
      n_fail++;
      $display("FAIL id_stall: got stall=%b flush=%b busy=%b, want stall=%b flush=0 busy=0",
               stall, flush, ex_mc_busy, S_ID);
    end
    tick();
    stallreq_id = 1'b0;
    #3;
    n_checks++;
    if ({stall, ex_mc_busy} !== {S_NONE, 1'b0}) begin
      n_fail++;
      $display("FAIL id_release: got stall=%b busy=%b, want stall=%b busy=0", stall, ex_mc_busy, S_NONE);
    end
    tick();
  endtask

  // N=4 started at k=0: EX stall k=0..3, done at k=4, busy k=1..4.
  task automatic test_mc4();
    logic [5:0] exp_stall;
    logic       exp_done;
    logic       exp_busy;
    for (int k = 0; k < 6; k++) begin
      ex_mc_start  = (k == 0);
      ex_mc_cycles = (k == 0) ? 6'd4 : 6'd0;
      exp_stall    = (k <= 3) ? S_EX : S_NONE;
      exp_done     = (k == 4);
      exp_busy     = (k >= 1) && (k <= 4);
      #3;
      n_checks++;
      if ({stall, ex_mc_done, ex_mc_busy} !== {exp_stall, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL mc4[T+%0d]: got stall=%b done=%b busy=%b, want stall=%b done=%b busy=%b",
                 k, stall, ex_mc_done, ex_mc_busy, exp_stall, exp_done, exp_busy);
      end
      tick();
    end
  endtask

  // N=0 and N=1 both hold EX only at T and pulse done at T+1.
  task automatic test_mc_short();
    logic [5:0] exp_stall;
    logic       exp_done;
    logic       exp_busy;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 3; k++) begin
        ex_mc_start  = (k == 0);
        ex_mc_cycles = 6'(n);
        exp_stall    = (k == 0) ? S_EX : S_NONE;
        exp_done     = (k == 1);
        exp_busy     = (k == 1);
        #3;
        n_checks++;
        if ({stall, ex_mc_done, ex_mc_busy} !== {exp_stall, exp_done, exp_busy}) begin
          n_fail++;
          $display("FAIL mc_short N=%0d [T+%0d]: got stall=%b done=%b busy=%b, want stall=%b done=%b busy=%b",
                   n, k, stall, ex_mc_done, ex_mc_busy, exp_stall, exp_done, exp_busy);
        end
        tick();
      end
    end
    clear_inputs();
  endtask

  // N=8 aborted by flush at T+3: no done pulse ever, IDLE from T+4.
  task automatic test_flush_abort();
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic        exp_busy;
    for (int k = 0; k < 11; k++) begin
      ex_mc_start  = (k == 0);
      ex_mc_cycles = (k == 0) ? 6'd8 : 6'd0;
      flush_req    = (k == 3);
      flush_pc     = (k == 3) ? 32'h0000_0100 : 32'h0;
      exp_stall    = (k <= 2) ? S_EX : S_NONE;
      exp_flush    = (k == 3);
      exp_pc       = (k == 3) ? 32'h0000_0100 : 32'h0;
      exp_busy     = (k >= 1) && (k <= 3);
      #3;
      n_checks++;
      if ({stall, flush, new_pc, ex_mc_done, ex_mc_busy} !== {exp_stall, exp_flush, exp_pc, 1'b0, exp_busy}) begin
        n_fail++;
        $display("FAIL flush_abort[T+%0d]: got stall=%b flush=%b new_pc=%h done=%b busy=%b, want stall=%b flush=%b new_pc=%h done=0 busy=%b",
                 k, stall, flush, new_pc, ex_mc_done, ex_mc_busy, exp_stall, exp_flush, exp_pc, exp_busy);
      end
      tick();
    end
    clear_inputs();
  endtask

  // stallreq_ex ORs with MC stall without touching cnt; ID stall honoured in the done cycle.
  task automatic test_ex_or_id();
    logic [5:0] exp_stall;
    logic       exp_done;
    logic       exp_busy;
    for (int k = 0; k < 4; k++) begin
      ex_mc_start  = (k == 0);
      ex_mc_cycles = (k == 0) ? 6'd2 : 6'd0;
      stallreq_ex  = (k <= 1);
      stallreq_id  = (k == 2);
      exp_stall    = (k <= 1) ? S_EX : ((k == 2) ? S_ID : S_NONE);
      exp_done     = (k == 2);
      exp_busy     = (k >= 1) && (k <= 2);
      #3;
      n_checks++;
      if ({stall, ex_mc_done, ex_mc_busy} !== {exp_stall, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL ex_or_id[T+%0d]: got stall=%b done=%b busy=%b, want stall=%b done=%b busy=%b",
                 k, stall, ex_mc_done, ex_mc_busy, exp_stall, exp_done, exp_busy);
      end
      tick();
    end
    clear_inputs();
  endtask

  // Priority: EX over ID, flush over everything, flush blocks an MC start.
  task automatic test_priority();
    stallreq_ex = 1'b1;
    stallreq_id = 1'b1;
    #3;
    n_checks++;
    if ({stall, flush} !== {S_EX, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_ex_id: got stall=%b flush=%b, want stall=%b flush=0", stall, flush, S_EX);
    end
    tick();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd3;
    flush_req    = 1'b1;
    flush_pc     = 32'h1234_5678;
    #3;
    n_checks++;
    if ({stall, flush, new_pc, ex_mc_done} !== {S_NONE, 1'b1, 32'h1234_5678, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_flush: got stall=%b flush=%b new_pc=%h done=%b, want stall=%b flush=1 new_pc=12345678 done=0",
               stall, flush, new_pc, ex_mc_done, S_NONE);
    end
    tick();
    clear_inputs();
    #3;
    n_checks++;
    if ({stall, ex_mc_busy, ex_mc_done} !== {S_NONE, 2'b00}) begin
      n_fail++;
      $display("FAIL prio_flush_nostart: got stall=%b busy=%b done=%b, want idle zeros",
               stall, ex_mc_busy, ex_mc_done);
    end
    tick();
  endtask

  // N=5 with a second start at T+2 that must be ignored; done at T+5.
  task automatic test_back_to_back();
    logic [5:0] exp_stall;
    logic       exp_done;
    logic       exp_busy;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ex_mc_start  = (k == 0) || (k == 2);
      ex_mc_cycles = (k == 0) ? 6'd5 : ((k == 2) ? 6'd2 : 6'd0);
      exp_stall    = (k <= 4) ? S_EX : S_NONE;
      exp_done     = (k == 5);
      exp_busy     = (k >= 1) && (k <= 5);
      #3;
      n_checks++;
      if ({stall, ex_mc_done, ex_mc_busy} !== {exp_stall, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL back_to_back[T+%0d]: got stall=%b done=%b busy=%b, want stall=%b done=%b busy=%b",
                 k, stall, ex_mc_done, ex_mc_busy, exp_stall, exp_done, exp_busy);
      end
      tick();
    end
    clear_inputs();
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if ({perf_stall_cyc, perf_flush_cnt} !== {32'd5, 32'd0}) begin
      n_fail++;
      $display("FAIL perf: got stall_cyc=%0d flush_cnt=%0d, want 5 and 0", perf_stall_cyc, perf_flush_cnt);
    end
`endif
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    test_reset();
    test_id_stall();
    test_mc4();
    test_mc_short();
    test_flush_abort();
    test_ex_or_id();
    test_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
